// File: rtl/sprite_pkg.sv
// sprite_pkg: register offsets, per-sprite register struct and bitmap depth
// shared by the multi-sprite video-slot core.
package sprite_pkg;
    localparam logic [1:0] CTRL   = 2'd0;
    localparam logic [1:0] X0     = 2'd1;
    localparam logic [1:0] Y0     = 2'd2;
    localparam logic [1:0] BYPASS = 2'd0;
    localparam logic [1:0] COMMIT = 2'd1;
    localparam int BMP_DEPTH_MAX  = 1024;
    typedef struct packed {
        logic        en;
        logic        mirror;
        logic [10:0] x0;
        logic [10:0] y0;
    } spr_regs_t;
endpackage

// File: rtl/vga_sprite_array_core_if.sv
// vga_sprite_array_core_if: video-slot bus plus pixel stream for the sprite core.
interface vga_sprite_array_core_if #(parameter int CD = 12);
    logic [10:0]   x;
    logic [10:0]   y;
    logic          cs;
    logic          write;
    logic [13:0]   addr;
    logic [31:0]   wr_data;
    logic [CD-1:0] si_rgb;
    logic [CD-1:0] so_rgb;
    logic          frame_tick;
    modport master (output x, y, cs, write, addr, wr_data, si_rgb, input so_rgb, frame_tick);
    modport slave  (input x, y, cs, write, addr, wr_data, si_rgb, output so_rgb, frame_tick);
endinterface

// File: rtl/sprite_bitmap_ram.sv
// sprite_bitmap_ram: 1W/1R synchronous bitmap RAM, one per sprite.
module sprite_bitmap_ram #(
    parameter int CD    = 12,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [CD-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [CD-1:0] rdata
);
    logic [CD-1:0] mem [DEPTH];
    logic [CD-1:0] rdata_q;
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata_q <= mem[raddr];
    end
    assign rdata = rdata_q;
endmodule

// File: rtl/vga_sprite_array_core.sv
// vga_sprite_array_core: NUM_SPR chroma-keyed sprites over the pixel stream, 2-cycle latency.
// Optional SPRITE_MIRROR_EN stores and applies the per-sprite h-mirror bit.
module vga_sprite_array_core
    import sprite_pkg::*;
#(
    parameter int CD = 12,
    parameter int NUM_SPR = 4,
    parameter int SPR_W = 32,
    parameter int SPR_H = 32,
    parameter logic [CD-1:0] KEY_COLOR = '0
) (
    input logic clk,
    input logic reset_n,
    vga_sprite_array_core_if.slave bus
);
    localparam int LW = $clog2(SPR_W);
    localparam int LH = $clog2(SPR_H);
    localparam int AW = LW + LH;
    localparam int DEPTH = SPR_W * SPR_H;

    logic we, reg_we, glb_we, commit, unused;
    logic byp_q, byp_d, pend_q, pend_d, tick_q, tick_d;
    logic [NUM_SPR-1:0] hit_q, hit_d;
    logic [CD-1:0] si_q, so_q, so_d, mix;
    logic [CD-1:0] rd [NUM_SPR];

    assign we = bus.cs & bus.write;
    assign reg_we = we & bus.addr[13] & ~bus.addr[6];
    assign glb_we = we & bus.addr[13] & bus.addr[6];
    assign commit = pend_q | (bus.x == '0 && bus.y == '0);
    assign unused = ^{bus.wr_data, bus.addr};

    for (genvar i = 0; i < NUM_SPR; i++) begin : g_spr
        spr_regs_t shd_q, shd_d, act_q, act_d;
        logic rsel, wsel;
        logic [11:0] dx, dy;
        logic [LW-1:0] px;
        assign rsel = reg_we && bus.addr[5:3] == 3'(i);
        assign wsel = we && !bus.addr[13] && bus.addr[12:10] == 3'(i);
        // shadow takes the write; active samples the pre-write shadow on commit
        always_comb begin
            shd_d.en = rsel && bus.addr[1:0] == CTRL ? bus.wr_data[0] : shd_q.en;
`ifdef SPRITE_MIRROR_EN
            shd_d.mirror = rsel && bus.addr[1:0] == CTRL ? bus.wr_data[1] : shd_q.mirror;
`else
            shd_d.mirror = 1'b0;
`endif
            shd_d.x0 = rsel && bus.addr[1:0] == X0 ? bus.wr_data[10:0] : shd_q.x0;
            shd_d.y0 = rsel && bus.addr[1:0] == Y0 ? bus.wr_data[10:0] : shd_q.y0;
            act_d = commit ? shd_q : act_q;
        end
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                shd_q <= '0;
                act_q <= '0;
            end else begin
                shd_q <= shd_d;
                act_q <= act_d;
            end
        end
        // 12-bit difference: a left-of-origin pixel wraps high and fails the bound
        assign dx = {1'b0, bus.x} - {1'b0, act_q.x0};
        assign dy = {1'b0, bus.y} - {1'b0, act_q.y0};
        assign hit_d[i] = act_q.en && dx < 12'(SPR_W) && dy < 12'(SPR_H);
        assign px = act_q.mirror ? ~dx[LW-1:0] : dx[LW-1:0];
        sprite_bitmap_ram #(.CD(CD), .DEPTH(DEPTH), .AW(AW)) u_ram (
            .clk   (clk),
            .we    (wsel),
            .waddr (bus.addr[AW-1:0]),
            .wdata (bus.wr_data[CD-1:0]),
            .raddr ({dy[LH-1:0], px}),
            .rdata (rd[i])
        );
    end

    always_comb begin
        byp_d = glb_we && bus.addr[1:0] == BYPASS ? bus.wr_data[0] : byp_q;
        pend_d = glb_we && bus.addr[1:0] == COMMIT && bus.wr_data[0];
        tick_d = commit;
        mix = si_q;
        for (int i = NUM_SPR - 1; i >= 0; i--)
            mix = hit_q[i] && rd[i] != KEY_COLOR ? rd[i] : mix;
        so_d = byp_d ? si_q : mix;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byp_q  <= 1'b0;
            pend_q <= 1'b0;
            tick_q <= 1'b0;
            hit_q  <= '0;
            si_q   <= '0;
            so_q   <= '0;
        end else begin
            byp_q  <= byp_d;
            pend_q <= pend_d;
            tick_q <= tick_d;
            hit_q  <= hit_d;
            si_q   <= bus.si_rgb;
            so_q   <= so_d;
        end
    end

    assign bus.so_rgb = so_q;
    assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_vga_sprite_array_core.sv
// tb_vga_sprite_array_core: directed pixel vectors with a scoreboard checked by a monitor.
module tb_vga_sprite_array_core;
    import sprite_pkg::*;

    typedef struct {
        int         due;
        logic [11:0] exp;
    } ent_t;

    logic clk = 1'b0;
    logic reset_n;
    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    ent_t sb[$];
    ent_t e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vga_sprite_array_core_if #(.CD(12)) bus ();

    vga_sprite_array_core #(
        .CD(12), .NUM_SPR(4), .SPR_W(32), .SPR_H(32), .KEY_COLOR(12'h000)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("pixel", bus.so_rgb, e.exp);
        end
    end

    task automatic drv(input int xx, input int yy, input logic [11:0] si, input bit c,
                       input logic [11:0] exp, input bit wen, input logic [13:0] a,
                       input logic [31:0] d);
        @(negedge clk);
        bus.x = 11'(xx);
        bus.y = 11'(yy);
        bus.si_rgb = si;
        bus.cs = wen;
        bus.write = wen;
        bus.addr = a;
        bus.wr_data = d;
        if (c) sb.push_back('{cyc + 2, exp});
    endtask

    task automatic px(input int xx, input int yy, input logic [11:0] si, input logic [11:0] exp);
        drv(xx, yy, si, 1'b1, exp, 1'b0, 14'h0, 32'h0);
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] d);
        drv(500, 500, 12'h0, 1'b0, 12'h0, 1'b1, a, d);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drv(500, 500, 12'h0, 1'b0, 12'h0, 1'b0, 14'h0, 32'h0);
    endtask

    task automatic drain();
        idle(3);
        chk("scoreboard_empty", 12'(sb.size()), 12'h0);
        sb.delete();
    endtask

    function automatic logic [13:0] ra(input int i, input logic [1:0] r);
        return 14'h2000 | 14'(i << 3) | 14'(r);
    endfunction

    function automatic logic [13:0] bm(input int i, input int p);
        return 14'(i << 10) | 14'(p);
    endfunction

    function automatic logic [13:0] gr(input logic [1:0] r);
        return 14'h2040 | 14'(r);
    endfunction

    task automatic commit_now();
        wr(gr(COMMIT), 32'h1);
        idle(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        bus.x = 11'd500;
        bus.y = 11'd500;
        bus.si_rgb = 12'hABC;
        bus.cs = 1'b0;
        bus.write = 1'b0;
        bus.addr = '0;
        bus.wr_data = '0;
        repeat (3) @(negedge clk);
        chk("reset_so", bus.so_rgb, 12'h000);
        chk("reset_tick", 12'(bus.frame_tick), 12'h0);
        @(negedge clk);
        reset_n = 1'b1;
        sb.push_back('{cyc + 2, 12'hABC});
        for (int k = 0; k < 3; k++) drv(500, 500, 12'hABC, 1'b0, 12'h0, 1'b0, 14'h0, 32'h0);
        drain();

        for (int p = 0; p < 1024; p++) wr(bm(0, p), 32'h0F0);
        wr(ra(0, X0), 32'd100);
        wr(ra(0, Y0), 32'd50);
        wr(ra(0, CTRL), 32'h1);
        commit_now();
        px(100, 50, 12'h123, 12'h0F0);
        px(99, 50, 12'h456, 12'h456);
        px(132, 50, 12'h789, 12'h789);
        px(131, 81, 12'h111, 12'h0F0);
        px(131, 82, 12'h222, 12'h222);
        px(100, 49, 12'h333, 12'h333);
        drain();

        for (int p = 0; p < 1024; p++) wr(bm(1, p), 32'hF00);
        wr(ra(1, X0), 32'd100);
        wr(ra(1, Y0), 32'd50);
        wr(ra(1, CTRL), 32'h1);
        wr(bm(0, 0), 32'h000);
        commit_now();
        px(100, 50, 12'h123, 12'hF00);
        px(101, 50, 12'h124, 12'h0F0);
        px(132, 50, 12'h125, 12'h125);
        wr(bm(0, 0), 32'h00F);
        px(100, 50, 12'h126, 12'h00F);
        drain();

        wr(ra(1, CTRL), 32'h0);
        commit_now();
        wr(ra(0, X0), 32'd200);
        idle(1);
        px(100, 50, 12'h126, 12'h00F);
        px(200, 50, 12'h127, 12'h127);
        drv(0, 0, 12'h128, 1'b1, 12'h128, 1'b1, ra(0, X0), 32'd300);
        px(1, 0, 12'h129, 12'h129);
        chk("tick_pulse", 12'(bus.frame_tick), 12'h1);
        px(2, 0, 12'h12A, 12'h12A);
        chk("tick_single", 12'(bus.frame_tick), 12'h0);
        px(200, 50, 12'h12B, 12'h00F);
        px(300, 50, 12'h12C, 12'h12C);
        px(0, 0, 12'h12D, 12'h12D);
        px(1, 0, 12'h12E, 12'h12E);
        px(300, 50, 12'h12F, 12'h00F);
        px(200, 50, 12'h130, 12'h130);
        drain();

        wr(gr(BYPASS), 32'h1);
        px(300, 50, 12'h777, 12'h777);
        idle(2);
        wr(gr(BYPASS), 32'h0);
        px(300, 50, 12'h778, 12'h00F);
        drain();

        wr(ra(0, X0), 32'd2040);
        commit_now();
        for (int xi = 0; xi < 32; xi++) px(xi, 50, 12'(12'h400 + xi), 12'(12'h400 + xi));
        px(2040, 50, 12'h501, 12'h00F);
        px(2047, 50, 12'h502, 12'h0F0);
        drain();

        wr(bm(0, 0), 32'h111);
        wr(ra(0, X0), 32'd100);
        wr(ra(0, CTRL), 32'h3);
        commit_now();
`ifdef SPRITE_MIRROR_EN
        px(131, 50, 12'h601, 12'h111);
        px(100, 50, 12'h602, 12'h0F0);
`else
        px(100, 50, 12'h601, 12'h111);
        px(131, 50, 12'h602, 12'h0F0);
`endif
        drain();

        for (int k = 0; k < 3; k++) drv(500, 500, 12'hABC, 1'b0, 12'h0, 1'b0, 14'h0, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("pre_reset_so", bus.so_rgb, 12'hABC);
        reset_n = 1'b0;
        #1;
        chk("async_reset_so", bus.so_rgb, 12'h000);
        @(negedge clk);
        reset_n = 1'b1;
        sb.push_back('{cyc + 2, 12'hABC});
        for (int k = 0; k < 3; k++) drv(500, 500, 12'hABC, 1'b0, 12'h0, 1'b0, 14'h0, 32'h0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vga_sprite_array_core.md
# vga_sprite_array_core

Multi-sprite video-slot core: parametrised successor to the single-sprite core. Overlays `NUM_SPR` independently positioned chroma-keyed sprites with fixed priority onto the incoming pixel stream. Control writes are double-buffered and committed at frame start, so a move never tears. Sits in the video pipeline between upstream stream cores and the downstream core, on one video-slot bus select.

## Interface

**Parameters**

- `CD`, 12: colour depth in bits.
- `NUM_SPR`, 4: sprite count, 1..8.
- `SPR_W`, 32: sprite width in pixels, a power of two. `SPR_W*SPR_H` must be ≤ 1024.
- `SPR_H`, 32: sprite height in pixels, a power of two.
- `KEY_COLOR`, 0: transparent colour value.

**Ports**

- `clk` in 1: the single clock. Video pixel clock domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `x`, `y` in 11 each: frame-counter coordinates of the current pixel.
- `cs`, `write` in 1 each: slot select and write strobe. A write occurs when both are 1.
- `addr` in 14: slot word address.
- `wr_data` in 32: write data.
- `si_rgb` in CD: stream in.
- `so_rgb` out CD: stream out, registered.
- `frame_tick` out 1: one-cycle pulse on the cycle the commit happens, registered.

## Operation

**Address map**

- `addr[13]=0` selects bitmap RAM.
  - `addr[12:10]` is the sprite index.
  - `addr[9:0]` is the pixel index, `py*SPR_W+px`.
  - The RAM stores `wr_data[CD-1:0]`.
  - Indices ≥ `NUM_SPR` are ignored.
- `addr[13]=1, addr[6]=0` selects per-sprite registers; `addr[5:3]` is the sprite index.
  - `addr[1:0]=0`: ctrl. `[0]` is enable; `[1]` is h-mirror (mirror only when compiled in).
  - `addr[1:0]=1`: `x0 <= wr_data[10:0]`.
  - `addr[1:0]=2`: `y0 <= wr_data[10:0]`.
  - `addr[1:0]=3`: ignored.
- `addr[13]=1, addr[6]=1` selects global registers.
  - `addr[1:0]=0`: bypass, from `wr_data[0]`. Takes effect immediately.
  - `addr[1:0]=1`: `commit_now`, a write-1 pulse that forces a commit on the next cycle.

**Shadow and commit**

- Per-sprite register writes land in shadow registers.
- Commit copies shadow to active on the cycle `x==0 && y==0`, or on the cycle after a `commit_now` write.
- Write and commit in the same cycle: active takes the old shadow value; the new value waits for the next commit.
- Bitmap RAM writes are not shadowed and are visible on the next read.

**Hit test (per sprite, on active registers)**

- `dx = {1'b0,x} - {1'b0,x0}`, computed in 12 bits. Hit requires `dx[11]==0` and `dx < SPR_W`; `dy` is computed the same way.
- No wrap-around: a sprite at `x0 > 2048-SPR_W` is clipped, never shown at the left edge.
- `px = mirror ? SPR_W-1-dx : dx`.

**Compositing**

- A sprite's pixel is opaque when the sprite is enabled, hit is true, and `ram != KEY_COLOR`.
- The lowest-index opaque sprite wins. If no sprite is opaque, `si_rgb` passes through.
- When bypass is set, `so_rgb` is the delayed `si_rgb`.

**Reset**

- All shadow and active registers, and bypass, are cleared to 0, so all sprites are disabled.
- `so_rgb=0`; `frame_tick=0`.
- Pipeline registers are cleared. RAM contents are undefined.

## Timing

- Fixed latency of 2 cycles from `x`/`y`/`si_rgb` to `so_rgb`.
  - Stage 1: hit test, RAM address, RAM read (synchronous). `si_rgb` and the hit/enable flags are registered.
  - Stage 2: key compare, priority mux, output register.
- `si_rgb` is delayed by exactly 2 cycles internally, so pixel alignment is preserved.
- `frame_tick` asserts 1 cycle after the commit cycle.
- A bypass write at cycle t affects `so_rgb` from cycle t+1.
- `reset_n` asserted mid-frame clears the output immediately (asynchronously). Pass-through resumes 2 cycles after release.

## Configuration

- `SPRITE_MIRROR_EN` defined: the ctrl `[1]` mirror bit is stored and applied per sprite.
- `SPRITE_MIRROR_EN` undefined: the mirror bit is not implemented and reads as 0; `px=dx`. All other behaviour is identical.

## Structure

- Package `sprite_pkg` holds:
  - register offsets (`CTRL`, `X0`, `Y0`, `BYPASS`, `COMMIT`);
  - the `spr_regs_t` struct (`en`, `mirror`, `x0`, `y0`);
  - the bitmap depth constant.
- Sub-module `sprite_bitmap_ram` is instantiated once per sprite via `generate`. It is a 1W/1R synchronous RAM, `SPR_W*SPR_H × CD`.

## Test plan

- **Reset:** hold `reset_n=0` with `si_rgb=12'hABC`. Expect `so_rgb=0`. Release; 2 cycles later expect `so_rgb=12'hABC`.
- **Single sprite:**
  - Setup: sprite 0 RAM filled with `12'h0F0`, `x0=100`, `y0=50`, enable, `commit_now`.
  - At `(100,50)`: `so_rgb=12'h0F0`, 2 cycles later.
  - At `(99,50)` and `(132,50)`: `so_rgb=si_rgb`.
- **Priority and key:**
  - Setup: sprites 0 and 1 overlap; sprite 0 pixel = `KEY_COLOR`, sprite 1 = `12'hF00`.
  - Expect `12'hF00`.
  - Set sprite 0 pixel to `12'h00F`; expect `12'h00F`.
- **Shadow commit:**
  - Write `x0=200` mid-frame. The sprite stays at the old position until `x=0,y=0`, then moves; `frame_tick` pulses once.
  - A write on the commit cycle itself takes effect the following frame.
- **Clip:** `x0=2040`. At `x=0..31`, no sprite pixels appear.
- **Mirror** (with `SPRITE_MIRROR_EN`): pixel 0 of row 0 = `12'h111`. With mirror set, `12'h111` appears at `x=x0+31`.
